// File: rtl/gf_inv_4_pipe_if.sv
// Handshake bundle for the pipelined GF(2^4) inverter: input nibble/tag stream,
// output inverse/tag stream and the pipeline occupancy count.
interface gf_inv_4_pipe_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       A;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       Q;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, A, in_tag, out_ready,
        output in_ready, out_valid, Q, out_tag, occupancy
    );

    modport master (
        output in_valid, A, in_tag, out_ready,
        input  in_ready, out_valid, Q, out_tag, occupancy
    );
endinterface

// File: rtl/gf_inv_4_pipe.sv
// Three-stage GF(2^4) inverter in normal basis [Y^4, Y] over GF(2^2) [Omega^2, Omega],
// with valid/ready flow control, collapsing bubbles and a sideband tag.
module gf_inv_4_pipe #(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gf_inv_4_pipe_if.slave     bus
);

    function automatic logic [1:0] gf_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // N*x^2 with N = Omega^2
    function automatic logic [1:0] gf_sq_scl(input logic [1:0] x);
        return {x[1], x[1] ^ x[0]};
    endfunction

    function automatic logic [1:0] gf_mul(input logic [1:0] x, input logic [1:0] y);
        logic t;
        t = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};
    endfunction

    logic             v1, v2, v3;
    logic [1:0]       a1, b1, t1;
    logic [1:0]       a2, b2, e2;
    logic [3:0]       q3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    logic [1:0]       occ;

    logic             adv2, adv3, in_rdy;
    logic             v1_nxt, v2_nxt, v3_nxt;
    logic [1:0]       a_in, b_in, t1_in;
    logic [1:0]       occ_nxt;

    // A stage may advance when the stage after it advances or is empty
    always_comb begin
        adv3   = bus.out_ready | ~v3;
        adv2   = adv3 | ~v2;
        in_rdy = adv2 | ~v1;
        v1_nxt = in_rdy ? bus.in_valid : v1;
        v2_nxt = adv2 ? v1 : v2;
        v3_nxt = adv3 ? v2 : v3;
        occ_nxt = 2'(v1_nxt) + 2'(v2_nxt) + 2'(v3_nxt);
    end

    always_comb begin
        a_in  = bus.A[3:2];
        b_in  = bus.A[1:0];
        t1_in = gf_sq_scl(a_in ^ b_in) ^ gf_mul(a_in, b_in);
    end

    // Data registers only load when a valid entry moves in, so stalled or idle stages keep their contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            t1   <= '0;
            tag1 <= '0;
            a2   <= '0;
            b2   <= '0;
            e2   <= '0;
            tag2 <= '0;
            q3   <= '0;
            tag3 <= '0;
            occ  <= '0;
        end else begin
            v1  <= v1_nxt;
            v2  <= v2_nxt;
            v3  <= v3_nxt;
            occ <= occ_nxt;
            if (in_rdy && bus.in_valid) begin
                a1   <= a_in;
                b1   <= b_in;
                t1   <= t1_in;
                tag1 <= bus.in_tag;
            end
            if (adv2 && v1) begin
                a2   <= a1;
                b2   <= b1;
                e2   <= gf_sq(t1);
                tag2 <= tag1;
            end
            if (adv3 && v2) begin
                q3   <= {gf_mul(e2, b2), gf_mul(e2, a2)};
                tag3 <= tag2;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v3;
    assign bus.Q         = q3;
    assign bus.out_tag   = tag3;
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_gf_inv_4_pipe.sv
// Scoreboard bench for gf_inv_4_pipe: expected inverses come from a brute-force
// search over a log-table GF(2^4) multiplier, checked by an independent monitor.
module tb_gf_inv_4_pipe;

    typedef struct {
        logic [3:0] q;
        logic [3:0] tag;
    } exp_t;

    logic clk;
    logic rst_n;
    gf_inv_4_pipe_if #(.TAG_W(4)) bus ();

    gf_inv_4_pipe #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          total_checks;
    int          passed_checks;
    int          out_count;
    int          accept_count;
    logic        checking;
    logic [15:0] seen_mask;

    // GF(2^2) multiply via discrete logs: 1 = 11, Omega = 01, Omega^2 = 10
    function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
        int lx, ly;
        logic [1:0] expo[3];
        expo[0] = 2'b11;
        expo[1] = 2'b01;
        expo[2] = 2'b10;
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        lx = (x == 2'b11) ? 0 : (x == 2'b01) ? 1 : 2;
        ly = (y == 2'b11) ? 0 : (y == 2'b01) ? 1 : 2;
        return expo[(lx + ly) % 3];
    endfunction

    // Normal-basis product (aY^4 + bY)(cY^4 + dY) with Y^2 + Y + N = 0, N = Omega^2
    function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] s;
        s = gf4_mul(2'b10, gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf4_mul(x[3:2], y[3:2]) ^ s, gf4_mul(x[1:0], y[1:0]) ^ s};
    endfunction

    function automatic logic [3:0] ref_inv(input logic [3:0] x);
        for (int c = 1; c < 16; c++) begin
            if (gf16_mul(x, 4'(c)) == 4'hF) return 4'(c);
        end
        return 4'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Drive one cycle of inputs, record any accepted transfer, return just after the next rising edge
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] tag, input logic rdy);
        exp_t e;
        bus.in_valid  = v;
        bus.A         = a;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
        @(negedge clk);
        #1;
        if (rst_n && checking && bus.in_valid && bus.in_ready) begin
            e.q   = ref_inv(a);
            e.tag = tag;
            sb.push_back(e);
            accept_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
            n++;
        end
        checkOutput("drain_done", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks occupancy, in_ready and stall stability
    initial begin
        exp_t       e;
        logic       prev_stall;
        logic [3:0] prev_q, prev_tag;
        prev_stall = 1'b0;
        prev_q     = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (checking) begin
                checkOutput("occupancy", 32'(bus.occupancy), 32'(sb.size()));
                checkOutput("in_ready", 32'(bus.in_ready), 32'((sb.size() < 3) || bus.out_ready));
                if (prev_stall) begin
                    checkOutput("q_hold", 32'(bus.Q), 32'(prev_q));
                    checkOutput("tag_hold", 32'(bus.out_tag), 32'(prev_tag));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        total_checks++;
                        $display("[TB] FAIL unexpected_output: got Q=%0h tag=%0h, expected none at %0t",
                                 bus.Q, bus.out_tag, $time);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("q_data", 32'(bus.Q), 32'(e.q));
                        checkOutput("q_tag", 32'(bus.out_tag), 32'(e.tag));
                        seen_mask[bus.Q] = 1'b1;
                        out_count++;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_q     = bus.Q;
                prev_tag   = bus.out_tag;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int base, acc0, cycles;
        total_checks  = 0;
        passed_checks = 0;
        out_count     = 0;
        accept_count  = 0;
        seen_mask     = '0;
        checking      = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = 4'h7;
        bus.in_tag    = 4'h3;
        bus.out_ready = 1'b0;

        // Reset held for two cycles with in_valid high
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);
        checkOutput("rst_q", 32'(bus.Q), 32'd0);
        checkOutput("rst_tag", 32'(bus.out_tag), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        checking     = 1'b1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Identity and zero, three-edge latency
        applyStimulus(1'b1, 4'hF, 4'h1, 1'b1);
        checkOutput("lat_edge0_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, 4'h0, 4'h2, 1'b1);
        checkOutput("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        checkOutput("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("inv_one", 32'(bus.Q), 32'hF);
        checkOutput("inv_one_tag", 32'(bus.out_tag), 32'd1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        checkOutput("inv_zero_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("inv_zero", 32'(bus.Q), 32'h0);
        checkOutput("inv_zero_tag", 32'(bus.out_tag), 32'd2);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);

        // Every nonzero nibble back-to-back; the inverses must cover 1..15
        seen_mask = '0;
        base      = out_count;
        for (int a = 1; a < 16; a++) applyStimulus(1'b1, 4'(a), 4'(a), 1'b1);
        repeat (3) applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        checkOutput("exh_count", 32'(out_count - base), 32'd15);
        checkOutput("exh_permutation", 32'(seen_mask), 32'hFFFE);

        // Fill under backpressure, then release for exactly one cycle
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'($urandom), 4'(i), 1'b0);
        applyStimulus(1'b1, 4'h5, 4'h7, 1'b0);
        applyStimulus(1'b1, 4'h6, 4'h7, 1'b0);
        checkOutput("full_occupancy", 32'(bus.occupancy), 32'd3);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        base = out_count;
        applyStimulus(1'b1, 4'h9, 4'h8, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0);
        checkOutput("bp_one_output", 32'(out_count - base), 32'd1);
        checkOutput("bp_occupancy", 32'(bus.occupancy), 32'd3);
        drainAll();

        // Random valid/ready at 50% each
        acc0   = accept_count;
        cycles = 0;
        while ((accept_count - acc0) < 10000 && cycles < 60000) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            cycles++;
        end
        checkOutput("random_accepts", 32'(accept_count - acc0), 32'd10000);
        drainAll();

        // Reset with two entries in flight discards them
        applyStimulus(1'b1, 4'h3, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h6, 4'h2, 1'b0);
        checkOutput("mid_occupancy", 32'(bus.occupancy), 32'd2);
        checking     = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_occupancy", 32'(bus.occupancy), 32'd0);
        checkOutput("midrst_q", 32'(bus.Q), 32'd0);
        rst_n    = 1'b1;
        checking = 1'b1;
        applyStimulus(1'b1, 4'hF, 4'h9, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1);
        checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("post_rst_q", 32'(bus.Q), 32'hF);
        checkOutput("post_rst_tag", 32'(bus.out_tag), 32'd9);
        drainAll();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/gf_inv_4_pipe.md
Name: gf_inv_4_pipe

Overview:
- Pipelined GF(2^4) inverter for the composite-field S-box datapath. Works in normal basis over GF(2^2), with GF(2^2) basis [Omega^2, Omega].
- Directly consumes the GF(2^2) square/inverse stage. It is the GF(2^4) layer that wraps that stage with scale, multiply and register boundaries.
- Three register stages with valid/ready flow control and a sideband tag. A multi-cycle S-box core can issue one nibble inversion per cycle under backpressure.

Parameters:
- TAG_W, 4, width of opaque sideband tag carried alongside each nibble (min 1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input nibble valid
- in_ready  out  1  block can accept input this cycle
- A  in  4  GF(2^4) operand; A[3:2]=high coefficient a, A[1:0]=low coefficient b
- in_tag  in  TAG_W  sideband tag for A
- out_valid  out  1  Q valid
- out_ready  in  1  downstream accepts Q this cycle
- Q  out  4  inverse of A; Q[3:2]=p, Q[1:0]=q
- out_tag  out  TAG_W  tag delivered with Q
- occupancy  out  2  number of valid stages (0..3)

Behaviour:
- Reset is synchronous and active-low. One clock; rst_n sampled only on the rising edge of clk.
- Reset values:
  - v1, v2, v3, out_valid, occupancy = 0.
  - Q, out_tag and all stage data = 0.
  - in_ready = 1 in the first cycle after reset release.
- GF(2^2) primitives, all combinational:
  - sq(x) = {x[0], x[1]}.
  - sq_scl(x) = {x[1], x[1]^x[0]}, i.e. N*x^2 with N = Omega^2.
  - mul(x,y): t = (x1^x0)&(y1^y0); result = {(x1&y1)^t, (x0&y0)^t}.
- Stage 1 captures a, b, t1 = sq_scl(a^b) ^ mul(a,b), and the tag.
- Stage 2 captures a, b, e = sq(t1), and the tag.
- Stage 3 captures Q = {mul(e,b), mul(e,a)} and the tag. Q/out_tag/out_valid are stage-3 registers.
- Latency: 3 cycles from an in_valid&in_ready edge to out_valid with no stalls. Throughput 1/cycle.
- Handshake:
  - Transfer occurs when valid&ready are both high at a rising edge.
  - adv3 = out_ready | ~v3; adv2 = adv3 | ~v2; in_ready = adv2 | ~v1.
  - in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
  - A stage loads from its predecessor when its adv is high. It becomes invalid if the predecessor is empty at that edge.
  - A stage holds data and tag unchanged when its adv is low.
  - Q/out_tag stay stable while out_valid=1 and out_ready=0.
- occupancy = v1+v2+v3, registered with the valids.
- Boundaries:
  - Full (occupancy 3) with out_ready=0: in_ready=0, input ignored, nothing changes.
  - Full with out_ready=1: simultaneous drain and accept; occupancy stays 3.
  - Bubbles collapse: an empty stage 2 lets stage 1 advance even if stage 3 is stalled.
  - A=0 gives Q=0 (defined extension, no error flag).
  - 1 is 4'b1111; inverse(1111)=1111.
  - rst_n low mid-operation discards all in-flight entries the same edge; no output is produced for them.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, occupancy=0, Q=0; after release in_ready=1.
- Identity/zero: A=4'hF tag=1, then A=4'h0 tag=2, out_ready=1 -> Q=4'hF tag 1 at cycle+3, Q=4'h0 tag 2 at cycle+4.
- Exhaustive: stream A=1..15 back-to-back, tags=A, out_ready=1 -> 15 outputs on consecutive cycles. Model GF(2^4) product of A and Q = 4'hF each time. inv(inv(A))=A. The 15 Q values are a permutation of 1..15.
- Backpressure: fill 3 entries with out_ready=0 -> occupancy=3, in_ready=0, Q stable. Raise out_ready one cycle -> exactly one output, in_ready=1 that cycle, occupancy stays 3 if in_valid=1.
- Random valid/ready at 50% each over 10k transactions -> output order and tags match input order, no loss or duplication, Q matches model.
- Reset mid-stream: assert rst_n=0 with occupancy=2 -> next cycle out_valid=0, occupancy=0. Subsequent A=4'hF returns 4'hF after 3 cycles.
